fxmem16_slave: RTL and testbench
================================

FXMEM16_SLAVE -- requirements
Module: fxmem16_slave

Interface
REQ-001 Parameter AW, default 10, meaning word-address width; the RAM holds 2^AW 16-bit words.
REQ-002 Parameter WAIT_CYCLES, default 1, legal range 0..15, meaning wait states inserted between request accept and response strobe.
REQ-003 clk_i  input  1  clock; all logic is on the rising edge of this single clock.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 sel_i  input  1  master select; a request is valid only while high.
REQ-006 stb_i  input  1  master request strobe, four-phase.
REQ-007 we_i  input  1  access type, active-low write: 0 = write, 1 = read.
REQ-008 addr_i  input  32  byte address; bit 0 is ignored; word index = addr_i[AW:1].
REQ-009 dat_o  input  16  write data from the master (interface field dat_o).
REQ-010 dat_i  output  16  read data to the master (interface field dat_i).
REQ-011 ack_o  output  1  slave ready; high only in IDLE.
REQ-012 cyc_o  output  1  cycle in progress; high from accept until response release.
REQ-013 stb_o  output  1  response strobe; high only in RESP.

Function
REQ-014 FSM states: IDLE, WAIT, RESP, RECOVER.
REQ-015 IDLE drives ack_o=1, cyc_o=0, stb_o=0.
REQ-016 IDLE transition on sel_i=1 and stb_i=1 at a clock edge:
  - latch addr_i, we_i and dat_o
  - ack_o<=0, cyc_o<=1
  - load wait counter with WAIT_CYCLES
  - go to WAIT
REQ-017 In IDLE, stb_i=1 with sel_i=0 is ignored; the FSM stays in IDLE.
REQ-018 WAIT with counter nonzero decrements the counter by 1.
REQ-019 WAIT with counter zero performs the access using the latched values:
  - write: RAM[word] <= latched data
  - read: dat_i <= RAM[word]
  - then stb_o<=1 and go to RESP
REQ-020 Accept edge to stb_o high latency is WAIT_CYCLES+1 cycles.
REQ-021 RESP holds stb_o=1 and cyc_o=1 until stb_i is sampled 0; on that edge stb_o<=0, cyc_o<=0 and the FSM goes to RECOVER.
REQ-022 dat_i is valid no later than the cycle cyc_o falls and holds until the next read access completes.
REQ-023 Writes do not alter dat_i.
REQ-024 RECOVER lasts exactly one cycle with ack_o=0, then the FSM goes to IDLE with ack_o<=1. This guarantees a master that samples !cyc_o && ack_o cannot see a stale ready.
REQ-025 Input changes on sel_i, we_i, addr_i and dat_o after accept have no effect on the current access.
REQ-026 stb_i falling during WAIT is not an abort: the access completes, stb_o pulses for one cycle, and the FSM then proceeds as in REQ-021.
REQ-027 Back-to-back write then read to the same word returns the newly written data.
REQ-028 Address wrap: without bounds checking, addr_i bits [31:AW+1] are ignored, so aliased addresses map onto RAM modulo 2^AW words.

Reset
REQ-029 On rst_i=1 at a clock edge:
  - FSM <= IDLE, wait counter <= 0
  - ack_o<=1, cyc_o<=0, stb_o<=0, dat_i<=16'h0000
REQ-030 Reset mid-operation (any state) abandons the access; a write not yet performed in WAIT is not committed.
REQ-031 RAM contents are not cleared by reset.
REQ-032 Asserting rst_i on the same edge as an accept results in IDLE; reset wins.

Configuration
REQ-033 Macro FXMEM16_BOUNDS_CHECK_EN, when defined, adds output err_o (1 bit, reset 0) and treats any access with addr_i[31:AW+1] != 0 as out of range:
  - writes are dropped
  - reads return dat_i=16'h0000
  - err_o is set sticky (cleared only by rst_i)
  - the handshake timing is unchanged
REQ-034 Without FXMEM16_BOUNDS_CHECK_EN, err_o does not exist and REQ-028 aliasing applies.

Verification
REQ-035 WAIT_CYCLES=1: write 16'hA5C3 to addr 32'h0000_0010, then read addr 32'h0000_0010 -> dat_i=16'hA5C3. Each access has stb_o rising 2 cycles after accept and ack_o high again 2 cycles after stb_i falls.
REQ-036 WAIT_CYCLES=0: read addr 32'h0000_0011 after writing 16'h1234 to addr 32'h0000_0010 -> dat_i=16'h1234 (bit 0 ignored); stb_o rises 1 cycle after accept.
REQ-037 Master holds stb_i high for 5 cycles in RESP -> stb_o stays high 5 cycles, cyc_o stays 1, and no second access occurs.
REQ-038 rst_i pulsed during WAIT of a write of 16'hFFFF to word 3, whose prior contents were 16'h0042 -> outputs take reset values; a subsequent read of word 3 returns 16'h0042.
REQ-039 With FXMEM16_BOUNDS_CHECK_EN and AW=10, write 16'hBEEF to addr 32'h0000_0800 -> err_o=1 and word 0 unchanged; a later read of 32'h0000_0800 returns 16'h0000. Without the macro, the same write lands in word 0.
REQ-040 stb_i=1 with sel_i=0 for 10 cycles in IDLE -> ack_o stays 1, cyc_o stays 0, and the RAM is unchanged.

Source files
------------

// File: rtl/fxmem16_slave.sv
// fxmem16_slave: 2^AW x 16-bit RAM slave behind a four-phase sel/stb handshake (optional macro FXMEM16_BOUNDS_CHECK_EN adds err_o).
// Latency: stb_o rises WAIT_CYCLES+1 cycles after the accept edge; one RECOVER cycle follows release.
// Backpressure: requests are accepted only in IDLE (ack_o=1); stb_o is held until the master drops stb_i.
module fxmem16_slave #(
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sel_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [15:0] dat_o,
    output logic [15:0] dat_i,
    output logic        ack_o,
    output logic        cyc_o,
    output logic        stb_o
`ifdef FXMEM16_BOUNDS_CHECK_EN
    ,
    output logic        err_o
`endif
);

    localparam int         DEPTH     = 1 << AW;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESP    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_word;
    logic          r_we;
    logic [15:0]   r_wdat;
    logic [15:0]   r_mem [0:DEPTH-1];
    logic          w_accept;
    logic          w_access;
    logic          w_oob;

    // Reset wins over both accept and the memory access on the same edge.
    assign w_accept = !rst_i && (r_state == S_IDLE) && sel_i && stb_i;
    assign w_access = !rst_i && (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef FXMEM16_BOUNDS_CHECK_EN
    logic r_oob;
    logic w_unused_addr;
    assign w_unused_addr = addr_i[0];
    assign w_oob         = r_oob;

    // Capture whether the accepted address lies outside the RAM.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_oob <= |addr_i[31:AW+1];
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (w_access && r_oob) begin
            err_o <= 1'b1;
        end
    end
`else
    // Upper address bits alias onto the RAM; byte bit 0 is never used.
    logic w_unused_addr;
    assign w_unused_addr = ^{addr_i[31:AW+1], addr_i[0]};
    assign w_oob         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (sel_i && stb_i)  w_next = S_WAIT;
            S_WAIT:    if (r_cnt == 4'd0)   w_next = S_RESP;
            S_RESP:    if (!stb_i)          w_next = S_RECOVER;
            S_RECOVER:                      w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    // Handshake outputs are pure functions of the registered state.
    always_comb begin
        ack_o = (r_state == S_IDLE);
        cyc_o = (r_state == S_WAIT) || (r_state == S_RESP);
        stb_o = (r_state == S_RESP);
    end

    // Wait-state counter: loaded on accept, counts down while waiting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= WAIT_INIT;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Latch the request so later input changes cannot disturb the access.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_word <= addr_i[AW:1];
            r_we   <= we_i;
            r_wdat <= dat_o;
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (w_access && !r_we && !w_oob) begin
            r_mem[r_word] <= r_wdat;
        end
    end

    // Read data register; only reads update it, out-of-range reads return zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dat_i <= 16'h0000;
        end else if (w_access && r_we) begin
            dat_i <= w_oob ? 16'h0000 : r_mem[r_word];
        end
    end

endmodule

// File: tb/tb_fxmem16_slave.sv
// tb_fxmem16_slave: checks two slaves (WAIT_CYCLES=1 and 0) driven by one master against a timeline model.
// Latency: outputs compared every falling edge; directed literals pin latencies and read data.
// Backpressure: master holds stb_i for a fixed number of cycles per access.
module tb_fxmem16_slave;

    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst, sel, stb, we;
    logic [31:0] addr;
    logic [15:0] wdat;
    logic [15:0] dat_a, dat_b;
    logic        ack_a, cyc_a, stb_a, ack_b, cyc_b, stb_b;
`ifdef FXMEM16_BOUNDS_CHECK_EN
    logic        err_a, err_b;
`endif

    always #5 clk = ~clk;

    fxmem16_slave #(.AW(AW), .WAIT_CYCLES(1)) u_w1 (
        .clk_i(clk), .rst_i(rst), .sel_i(sel), .stb_i(stb), .we_i(we),
        .addr_i(addr), .dat_o(wdat), .dat_i(dat_a),
        .ack_o(ack_a), .cyc_o(cyc_a), .stb_o(stb_a)
`ifdef FXMEM16_BOUNDS_CHECK_EN
        , .err_o(err_a)
`endif
    );

    fxmem16_slave #(.AW(AW), .WAIT_CYCLES(0)) u_w0 (
        .clk_i(clk), .rst_i(rst), .sel_i(sel), .stb_i(stb), .we_i(we),
        .addr_i(addr), .dat_o(wdat), .dat_i(dat_b),
        .ack_o(ack_b), .cyc_o(cyc_b), .stb_o(stb_b)
`ifdef FXMEM16_BOUNDS_CHECK_EN
        , .err_o(err_b)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Timeline model: index 0 = WAIT_CYCLES 1, index 1 = WAIT_CYCLES 0.
    // m_t counts edges since accept; access happens at m_t == W+1, release on the
    // first later edge with stb_i low, idle one edge after release.
    int          wcy [2] = '{1, 0};
    bit          m_act [2];
    bit          m_rel [2];
    int          m_t [2];
    logic [31:0] m_la [2];
    bit          m_lw [2];
    logic [15:0] m_ld [2];
    logic [15:0] m_dat [2] = '{16'h0, 16'h0};
    bit          m_dk [2] = '{1'b1, 1'b1};
    bit          m_err [2];
    logic [15:0] mm [2][1024];
    bit          mk [2][1024];
    bit          started = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_act[k] = 1'b0;
                m_dat[k] = 16'h0;
                m_dk[k]  = 1'b1;
                m_err[k] = 1'b0;
            end else if (!m_act[k]) begin
                if (sel && stb) begin
                    m_act[k] = 1'b1;
                    m_rel[k] = 1'b0;
                    m_t[k]   = 0;
                    m_la[k]  = addr;
                    m_lw[k]  = !we;
                    m_ld[k]  = wdat;
                end
            end else begin
                m_t[k]++;
                if (m_rel[k]) begin
                    m_act[k] = 1'b0;
                end else if (m_t[k] == wcy[k] + 1) begin
                    int  w;
                    bit  oob;
                    w   = int'(m_la[k][AW:1]);
                    oob = 1'b0;
`ifdef FXMEM16_BOUNDS_CHECK_EN
                    oob = (m_la[k][31:AW+1] != '0);
                    if (oob) m_err[k] = 1'b1;
`endif
                    if (m_lw[k]) begin
                        if (!oob) begin
                            mm[k][w] = m_ld[k];
                            mk[k][w] = 1'b1;
                        end
                    end else begin
                        m_dat[k] = oob ? 16'h0 : mm[k][w];
                        m_dk[k]  = oob ? 1'b1 : mk[k][w];
                    end
                end else if ((m_t[k] > wcy[k] + 1) && !stb) begin
                    m_rel[k] = 1'b1;
                end
            end
        end
    end

    // Every falling edge: both DUTs against the model.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                logic        a_ack, a_cyc, a_stb;
                logic [15:0] a_dat;
                a_ack = (k == 0) ? ack_a : ack_b;
                a_cyc = (k == 0) ? cyc_a : cyc_b;
                a_stb = (k == 0) ? stb_a : stb_b;
                a_dat = (k == 0) ? dat_a : dat_b;
                chk1($sformatf("model ack_o W%0d", wcy[k]), a_ack, !m_act[k]);
                chk1($sformatf("model cyc_o W%0d", wcy[k]), a_cyc, m_act[k] && !m_rel[k]);
                chk1($sformatf("model stb_o W%0d", wcy[k]), a_stb,
                     m_act[k] && !m_rel[k] && (m_t[k] >= wcy[k] + 1));
                if (m_dk[k]) chk16($sformatf("model dat_i W%0d", wcy[k]), a_dat, m_dat[k]);
`ifdef FXMEM16_BOUNDS_CHECK_EN
                chk1($sformatf("model err_o W%0d", wcy[k]), (k == 0) ? err_a : err_b, m_err[k]);
`endif
            end
        end
    end

    // One access: stb_i high for 'hold' falling edges (inputs scrambled after accept), then idle.
    task automatic access(input bit wr, input logic [31:0] a, input logic [15:0] d,
                          input int hold, output int ns1, output int ns0);
        ns1 = 0;
        ns0 = 0;
        sel  = 1'b1;
        stb  = 1'b1;
        we   = !wr;
        addr = a;
        wdat = d;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            ns1 += int'(stb_a);
            ns0 += int'(stb_b);
            addr = $urandom;
            wdat = 16'($urandom);
            we   = 1'($urandom);
        end
        sel = 1'b0;
        stb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ns1 += int'(stb_a);
            ns0 += int'(stb_b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int n1, n0;
        rst = 1'b1; sel = 1'b0; stb = 1'b0; we = 1'b1; addr = '0; wdat = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk1("reset ack_o", ack_a, 1'b1);
        chk1("reset cyc_o", cyc_a, 1'b0);
        chk1("reset stb_o", stb_a, 1'b0);
        chk16("reset dat_i", dat_a, 16'h0000);

        // Write A5C3 to 0x10 with cycle-by-cycle latency checks; inputs change after accept.
        @(negedge clk);
        sel = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h10; wdat = 16'hA5C3;
        @(negedge clk);
        chk1("accept cyc_o", cyc_a, 1'b1);
        chk1("accept ack_o", ack_a, 1'b0);
        chk1("accept stb_o", stb_a, 1'b0);
        sel = 1'b0; we = 1'b1; addr = 32'h3FE; wdat = 16'hDEAD;
        @(negedge clk);
        chk1("W1 stb_o +1", stb_a, 1'b0);
        chk1("W0 stb_o +1", stb_b, 1'b1);
        @(negedge clk);
        chk1("W1 stb_o +2", stb_a, 1'b1);
        stb = 1'b0;
        @(negedge clk);
        chk1("release cyc_o", cyc_a, 1'b0);
        chk1("release stb_o", stb_a, 1'b0);
        chk1("recover ack_o", ack_a, 1'b0);
        @(negedge clk);
        chk1("ready ack_o", ack_a, 1'b1);
        repeat (2) @(negedge clk);

        access(1'b0, 32'h10, 16'h0, 3, n1, n0);
        chk16("read A5C3 W1", dat_a, 16'hA5C3);
        chk16("read A5C3 W0", dat_b, 16'hA5C3);
        chkn("stb pulse hold3 W1", n1, 1);
        chkn("stb pulse hold3 W0", n0, 2);

        // Write then read with byte bit 0 set.
        access(1'b1, 32'h10, 16'h1234, 3, n1, n0);
        access(1'b0, 32'h11, 16'h0, 3, n1, n0);
        chk16("read 0x11 W1", dat_a, 16'h1234);
        chk16("read 0x11 W0", dat_b, 16'h1234);

        // Master lingers in RESP.
        access(1'b0, 32'h10, 16'h0, 7, n1, n0);
        chkn("stb long hold W1", n1, 5);
        chkn("stb long hold W0", n0, 6);

        // stb_i dropped right after accept.
        access(1'b0, 32'h10, 16'h0, 1, n1, n0);
        chkn("stb early drop W1", n1, 1);
        chkn("stb early drop W0", n0, 1);

        access(1'b1, 32'h20, 16'h5555, 3, n1, n0);
        chk16("write keeps dat_i", dat_a, 16'h1234);

        // Reset together with accept, then reset during WAIT of a write.
        access(1'b1, 32'h6, 16'h0042, 3, n1, n0);
        rst = 1'b1; sel = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h6; wdat = 16'hFFFF;
        @(negedge clk);
        chk1("rst+accept ack_o", ack_a, 1'b1);
        chk1("rst+accept cyc_o", cyc_a, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk1("accept after rst cyc_o", cyc_a, 1'b1);
        rst = 1'b1; sel = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk1("mid rst ack_o", ack_a, 1'b1);
        chk1("mid rst cyc_o W0", cyc_b, 1'b0);
        chk16("mid rst dat_i", dat_a, 16'h0000);
        @(negedge clk);
        access(1'b0, 32'h6, 16'h0, 3, n1, n0);
        chk16("word3 kept W1", dat_a, 16'h0042);
        chk16("word3 kept W0", dat_b, 16'h0042);

        // Address beyond 2^AW words.
        access(1'b1, 32'h0, 16'h1111, 3, n1, n0);
        access(1'b1, 32'h800, 16'hBEEF, 3, n1, n0);
`ifdef FXMEM16_BOUNDS_CHECK_EN
        chk1("oob err_o", err_a, 1'b1);
        access(1'b0, 32'h0, 16'h0, 3, n1, n0);
        chk16("word0 untouched", dat_a, 16'h1111);
        access(1'b0, 32'h800, 16'h0, 3, n1, n0);
        chk16("oob read zero", dat_a, 16'h0000);
`else
        access(1'b0, 32'h0, 16'h0, 3, n1, n0);
        chk16("alias into word0", dat_a, 16'hBEEF);
`endif

        // stb_i without sel_i is ignored.
        sel = 1'b0; stb = 1'b1; we = 1'b0; addr = 32'h0; wdat = 16'h7777;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("nosel ack_o", ack_a, 1'b1);
            chk1("nosel cyc_o", cyc_a, 1'b0);
        end
        stb = 1'b0;
        @(negedge clk);
        access(1'b0, 32'h0, 16'h0, 3, n1, n0);
`ifdef FXMEM16_BOUNDS_CHECK_EN
        chk16("nosel ram intact", dat_a, 16'h1111);
`else
        chk16("nosel ram intact", dat_a, 16'hBEEF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
